// File: rtl/trigger_array_pkg.sv
// Shared types and return codes for the multi-lane actor trigger.
// Lane FSM states, lane modes and the 32-bit HLS actor return codes live here.
package trigger_array_pkg;

  typedef enum logic [3:0] {
    IDLE_STATE  = 4'd0,
    LAUNCH      = 4'd1,
    CHECK       = 4'd2,
    SLEEP       = 4'd3,
    SYNC_LAUNCH = 4'd4,
    SYNC_CHECK  = 4'd5,
    SYNC_WAIT   = 4'd6,
    SYNC_EXEC   = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    ACTOR_TRIGGER  = 2'd0,
    INPUT_TRIGGER  = 2'd1,
    OUTPUT_TRIGGER = 2'd2
  } mode_t;

  // Any other return value is treated as "not executed".
  localparam logic [31:0] IDLE     = 32'd0;
  localparam logic [31:0] WAIT     = 32'd1;
  localparam logic [31:0] TEST     = 32'd2;
  localparam logic [31:0] EXECUTED = 32'd3;

  // States in which the actor is running and its done/return are meaningful.
  function automatic logic is_issue_state(input logic [3:0] s);
    return (s == LAUNCH) || (s == CHECK) || (s == SYNC_LAUNCH) || (s == SYNC_CHECK);
  endfunction

endpackage

// File: rtl/trigger_array_lane.sv
// One lane of the trigger array: the per-actor scheduling FSM plus its
// sleep-retry timer. Consensus bits come from the array and are shared.
module trigger_lane
  import trigger_array_pkg::*;
#(
  parameter int SLEEP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        run_start,
  input  logic        all_sleep,
  input  logic        all_sync,
  input  logic        all_sync_wait,
  input  logic        done,
  input  logic [31:0] ret,
  input  logic        enqueue,
  output logic [3:0]  state,
  output logic        start
);

  localparam int TW = (SLEEP_TIMEOUT > 1) ? $clog2(SLEEP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (SLEEP_TIMEOUT > 0) ? TW'(SLEEP_TIMEOUT - 1) : '0;

  state_t         state_q;
  state_t         state_d;
  logic [TW-1:0]  timer_q;
  mode_t          lane_mode;
  logic           is_actor;
  logic           progress;
  logic           timed_out;

  assign lane_mode = mode_t'(mode);
  assign is_actor  = (lane_mode == ACTOR_TRIGGER);
  assign progress  = (ret == EXECUTED) || (ret == TEST) || enqueue;
  assign timed_out = (SLEEP_TIMEOUT > 0) && (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_STATE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      // Counts cycles spent in SLEEP; entering SLEEP always sees zero.
      if (state_q == SLEEP) timer_q <= timer_q + 1'b1;
      else                  timer_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_STATE: begin
        if (run_start) state_d = (lane_mode == OUTPUT_TRIGGER) ? SLEEP : LAUNCH;
      end
      LAUNCH, CHECK: begin
        if (!done)         state_d = CHECK;
        else if (progress) state_d = is_actor ? LAUNCH : SLEEP;
        else               state_d = is_actor ? SLEEP : IDLE_STATE;
      end
      SLEEP: begin
        // Consensus has priority over a timeout in the same cycle.
        if (all_sleep)      state_d = is_actor ? SYNC_LAUNCH : LAUNCH;
        else if (timed_out) state_d = LAUNCH;
      end
      SYNC_LAUNCH, SYNC_CHECK: begin
        if (!done)                  state_d = SYNC_CHECK;
        else if (ret == EXECUTED)   state_d = SYNC_EXEC;
        else if (ret == TEST)       state_d = SYNC_LAUNCH;
        else                        state_d = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (all_sync) state_d = all_sync_wait ? IDLE_STATE : LAUNCH;
      end
      SYNC_EXEC: begin
        if (all_sync) state_d = LAUNCH;
      end
      default: state_d = IDLE_STATE;
    endcase
  end

  assign state = state_q;
  assign start = (state_q == LAUNCH) || (state_q == SYNC_LAUNCH);

endmodule

// File: rtl/trigger_array.sv
// Multi-lane actor trigger: one ap_start/ap_done run drives NUM_LANES lane
// FSMs that agree on sleep/sync through internally reduced consensus.
module trigger_array
  import trigger_array_pkg::*;
#(
  parameter int                     NUM_LANES     = 4,
  parameter logic [2*NUM_LANES-1:0] LANE_MODES    = '0,
  parameter int                     SLEEP_TIMEOUT = 0,
  parameter int                     CNT_W         = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic                    ap_idle,
  input  logic [NUM_LANES-1:0]    external_enqueue,
  input  logic [32*NUM_LANES-1:0] actor_return,
  input  logic [NUM_LANES-1:0]    actor_done,
  input  logic [NUM_LANES-1:0]    actor_idle,
  output logic [NUM_LANES-1:0]    actor_start,
  output logic [4*NUM_LANES-1:0]  lane_state,
  output logic [CNT_W-1:0]        exec_count
);

  localparam int IW = $clog2(NUM_LANES + 1);
  localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic           running_q;
  logic           done_q;
  logic           start_accept;
  logic           all_sleep;
  logic           all_sync;
  logic           all_sync_wait;
  logic           all_idle;
  logic [IW-1:0]  exec_inc;
  logic [SW-1:0]  exec_sum;
  logic [CNT_W-1:0] exec_count_q;
  logic           unused_actor_idle;

  // Handshake: ap_start is taken only while ap_idle is high (no run active);
  // the run ends with a single registered ap_done/ap_ready pulse, and ap_idle
  // rises on that same cycle so a new ap_start may follow immediately.
  assign start_accept = ap_start && !running_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    trigger_lane #(
      .SLEEP_TIMEOUT(SLEEP_TIMEOUT)
    ) u_lane (
      .clk          (ap_clk),
      .rst_n        (ap_rst_n),
      .mode         (LANE_MODES[2*i +: 2]),
      .run_start    (start_accept),
      .all_sleep    (all_sleep),
      .all_sync     (all_sync),
      .all_sync_wait(all_sync_wait),
      .done         (actor_done[i]),
      .ret          (actor_return[32*i +: 32]),
      .enqueue      (external_enqueue[i]),
      .state        (lane_state[4*i +: 4]),
      .start        (actor_start[i])
    );
  end

  // Consensus and executed-return count, all from registered lane states.
  always_comb begin
    all_sleep     = 1'b1;
    all_sync      = 1'b1;
    all_sync_wait = 1'b1;
    all_idle      = 1'b1;
    exec_inc      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!((lane_state[4*i +: 4] == SLEEP) || (lane_state[4*i +: 4] == IDLE_STATE)))
        all_sleep = 1'b0;
      if (!((lane_state[4*i +: 4] == SYNC_WAIT) || (lane_state[4*i +: 4] == SYNC_EXEC) ||
            (lane_state[4*i +: 4] == IDLE_STATE)))
        all_sync = 1'b0;
      if (!((lane_state[4*i +: 4] == SYNC_WAIT) || (lane_state[4*i +: 4] == IDLE_STATE)))
        all_sync_wait = 1'b0;
      if (lane_state[4*i +: 4] != IDLE_STATE)
        all_idle = 1'b0;
      if (actor_done[i] && (actor_return[32*i +: 32] == EXECUTED) &&
          is_issue_state(lane_state[4*i +: 4]))
        exec_inc = exec_inc + IW'(1);
    end
  end

  assign exec_sum = SW'(exec_count_q) + SW'(exec_inc);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      exec_count_q <= '0;
    end else begin
      done_q <= running_q && all_idle;
      if (start_accept)               running_q <= 1'b1;
      else if (running_q && all_idle) running_q <= 1'b0;

      if (start_accept)             exec_count_q <= '0;
      else if (exec_sum > CNT_MAX)  exec_count_q <= '1;
      else                          exec_count_q <= exec_sum[CNT_W-1:0];
    end
  end

  // actor_idle is observational only; it does not influence scheduling.
  assign unused_actor_idle = ^actor_idle;

  assign ap_done    = done_q;
  assign ap_ready   = done_q;
  assign ap_idle    = !running_q;
  assign exec_count = exec_count_q;

endmodule

// File: tb/tb_trigger_array.sv
// Directed bench for trigger_array: three 2-lane configurations sharing one
// clock and reset, each scenario checked against hand-computed values.
module tb_trigger_array;
  import trigger_array_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // dut_a: two ACTOR lanes, no timeout, 32-bit counter
  logic        start_a;
  logic [1:0]  enq_a, done_a, idle_a, astart_a;
  logic [63:0] ret_a;
  logic        ap_done_a, ap_ready_a, ap_idle_a;
  logic [7:0]  state_a;
  logic [31:0] cnt_a;

  // dut_b: lane0 ACTOR, lane1 OUTPUT, no timeout, 2-bit counter
  logic        start_b;
  logic [1:0]  enq_b, done_b, idle_b, astart_b;
  logic [63:0] ret_b;
  logic        ap_done_b, ap_ready_b, ap_idle_b;
  logic [7:0]  state_b;
  logic [1:0]  cnt_b;

  // dut_c: lane0 OUTPUT, lane1 ACTOR, SLEEP_TIMEOUT=8, 8-bit counter
  logic        start_c;
  logic [1:0]  enq_c, done_c, idle_c, astart_c;
  logic [63:0] ret_c;
  logic        ap_done_c, ap_ready_c, ap_idle_c;
  logic [7:0]  state_c;
  logic [7:0]  cnt_c;

  trigger_array #(.NUM_LANES(2), .LANE_MODES(4'b0000), .SLEEP_TIMEOUT(0), .CNT_W(32)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_a), .ap_done(ap_done_a),
    .ap_ready(ap_ready_a), .ap_idle(ap_idle_a), .external_enqueue(enq_a),
    .actor_return(ret_a), .actor_done(done_a), .actor_idle(idle_a),
    .actor_start(astart_a), .lane_state(state_a), .exec_count(cnt_a)
  );

  trigger_array #(.NUM_LANES(2), .LANE_MODES(4'b1000), .SLEEP_TIMEOUT(0), .CNT_W(2)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_b), .ap_done(ap_done_b),
    .ap_ready(ap_ready_b), .ap_idle(ap_idle_b), .external_enqueue(enq_b),
    .actor_return(ret_b), .actor_done(done_b), .actor_idle(idle_b),
    .actor_start(astart_b), .lane_state(state_b), .exec_count(cnt_b)
  );

  trigger_array #(.NUM_LANES(2), .LANE_MODES(4'b0010), .SLEEP_TIMEOUT(8), .CNT_W(8)) dut_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_c), .ap_done(ap_done_c),
    .ap_ready(ap_ready_c), .ap_idle(ap_idle_c), .external_enqueue(enq_c),
    .actor_return(ret_c), .actor_done(done_c), .actor_idle(idle_c),
    .actor_start(astart_c), .lane_state(state_c), .exec_count(cnt_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; enq_a = 0; done_a = 0; idle_a = 2'b11; ret_a = '0;
    start_b = 0; enq_b = 0; done_b = 0; idle_b = 2'b11; ret_b = '0;
    start_c = 0; enq_c = 0; done_c = 0; idle_c = 2'b11; ret_c = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    n_checks++; if (state_a !== 8'h00) $display("FAIL reset_state got=%h exp=%h", state_a, 8'h00); else n_pass++;
    n_checks++; if (astart_a !== 2'b00) $display("FAIL reset_start got=%b exp=%b", astart_a, 2'b00); else n_pass++;
    n_checks++; if (ap_idle_a !== 1'b1) $display("FAIL reset_idle got=%b exp=1", ap_idle_a); else n_pass++;
    n_checks++; if (ap_done_a !== 1'b0) $display("FAIL reset_done got=%b exp=0", ap_done_a); else n_pass++;
    n_checks++; if (cnt_a !== 32'd0) $display("FAIL reset_count got=%0d exp=0", cnt_a); else n_pass++;
  endtask

  task automatic test_full_run();
    start_a = 1; step(); start_a = 0;
    n_checks++; if (state_a !== {LAUNCH, LAUNCH}) $display("FAIL run_launch got=%h exp=%h", state_a, {LAUNCH, LAUNCH}); else n_pass++;
    n_checks++; if (astart_a !== 2'b11) $display("FAIL run_astart got=%b exp=11", astart_a); else n_pass++;
    n_checks++; if (ap_idle_a !== 1'b0) $display("FAIL run_busy got=%b exp=0", ap_idle_a); else n_pass++;
    done_a = 2'b11; ret_a = {EXECUTED, EXECUTED};
    repeat (3) step();
    n_checks++; if (state_a !== {LAUNCH, LAUNCH}) $display("FAIL run_relaunch got=%h exp=%h", state_a, {LAUNCH, LAUNCH}); else n_pass++;
    n_checks++; if (cnt_a !== 32'd6) $display("FAIL run_count6 got=%0d exp=6", cnt_a); else n_pass++;
    ret_a = {IDLE, IDLE}; step(); done_a = 0;
    n_checks++; if (state_a !== {SLEEP, SLEEP}) $display("FAIL run_sleep got=%h exp=%h", state_a, {SLEEP, SLEEP}); else n_pass++;
    n_checks++; if (astart_a !== 2'b00) $display("FAIL run_sleep_astart got=%b exp=00", astart_a); else n_pass++;
    step();
    n_checks++; if (state_a !== {SYNC_LAUNCH, SYNC_LAUNCH}) $display("FAIL run_sync_launch got=%h exp=%h", state_a, {SYNC_LAUNCH, SYNC_LAUNCH}); else n_pass++;
    n_checks++; if (astart_a !== 2'b11) $display("FAIL run_sync_astart got=%b exp=11", astart_a); else n_pass++;
    done_a = 2'b11; ret_a = {WAIT, WAIT}; step(); done_a = 0;
    n_checks++; if (state_a !== {SYNC_WAIT, SYNC_WAIT}) $display("FAIL run_sync_wait got=%h exp=%h", state_a, {SYNC_WAIT, SYNC_WAIT}); else n_pass++;
    step();
    n_checks++; if (state_a !== {IDLE_STATE, IDLE_STATE}) $display("FAIL run_all_idle got=%h exp=00", state_a); else n_pass++;
    n_checks++; if (ap_done_a !== 1'b0) $display("FAIL run_done_early got=%b exp=0", ap_done_a); else n_pass++;
    step();
    n_checks++; if (ap_done_a !== 1'b1) $display("FAIL run_done_pulse got=%b exp=1", ap_done_a); else n_pass++;
    n_checks++; if (ap_ready_a !== 1'b1) $display("FAIL run_ready_pulse got=%b exp=1", ap_ready_a); else n_pass++;
    n_checks++; if (ap_idle_a !== 1'b1) $display("FAIL run_idle_end got=%b exp=1", ap_idle_a); else n_pass++;
    step();
    n_checks++; if (ap_done_a !== 1'b0) $display("FAIL run_done_single got=%b exp=0", ap_done_a); else n_pass++;
    n_checks++; if (cnt_a !== 32'd6) $display("FAIL run_count_held got=%0d exp=6", cnt_a); else n_pass++;
  endtask

  task automatic test_sync_exec();
    start_a = 1; step(); start_a = 0;
    done_a = 2'b11; ret_a = {IDLE, IDLE}; step(); done_a = 0;
    step();
    done_a = 2'b11; ret_a = {WAIT, EXECUTED}; step(); done_a = 0;
    n_checks++; if (state_a !== {SYNC_WAIT, SYNC_EXEC}) $display("FAIL sync_split got=%h exp=%h", state_a, {SYNC_WAIT, SYNC_EXEC}); else n_pass++;
    n_checks++; if (cnt_a !== 32'd1) $display("FAIL sync_count got=%0d exp=1", cnt_a); else n_pass++;
    step();
    n_checks++; if (state_a !== {LAUNCH, LAUNCH}) $display("FAIL sync_relaunch got=%h exp=%h", state_a, {LAUNCH, LAUNCH}); else n_pass++;
    n_checks++; if (ap_done_a !== 1'b0) $display("FAIL sync_no_done got=%b exp=0", ap_done_a); else n_pass++;
  endtask

  task automatic test_start_ignored();
    step();
    n_checks++; if (state_a !== {CHECK, CHECK}) $display("FAIL busy_check got=%h exp=%h", state_a, {CHECK, CHECK}); else n_pass++;
    start_a = 1; step(); start_a = 0;
    n_checks++; if (state_a !== {CHECK, CHECK}) $display("FAIL start_ignored_state got=%h exp=%h", state_a, {CHECK, CHECK}); else n_pass++;
    n_checks++; if (cnt_a !== 32'd1) $display("FAIL start_ignored_count got=%0d exp=1", cnt_a); else n_pass++;
    n_checks++; if (ap_idle_a !== 1'b0) $display("FAIL start_ignored_idle got=%b exp=0", ap_idle_a); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state_a !== 8'h00) $display("FAIL areset_state got=%h exp=00", state_a); else n_pass++;
    n_checks++; if (astart_a !== 2'b00) $display("FAIL areset_astart got=%b exp=00", astart_a); else n_pass++;
    n_checks++; if (ap_idle_a !== 1'b1) $display("FAIL areset_idle got=%b exp=1", ap_idle_a); else n_pass++;
    n_checks++; if (cnt_a !== 32'd0) $display("FAIL areset_count got=%0d exp=0", cnt_a); else n_pass++;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (ap_done_a !== 1'b0) $display("FAIL areset_no_done cycle=%0d got=%b exp=0", k, ap_done_a); else n_pass++;
    end
  endtask

  task automatic test_output_lane();
    start_b = 1; step(); start_b = 0;
    n_checks++; if (state_b !== {SLEEP, LAUNCH}) $display("FAIL out_start got=%h exp=%h", state_b, {SLEEP, LAUNCH}); else n_pass++;
    n_checks++; if (astart_b !== 2'b01) $display("FAIL out_astart got=%b exp=01", astart_b); else n_pass++;
    done_b = 2'b01; ret_b = {IDLE, EXECUTED};
    step(); step();
    n_checks++; if (cnt_b !== 2'd2) $display("FAIL sat_count2 got=%0d exp=2", cnt_b); else n_pass++;
    step();
    n_checks++; if (cnt_b !== 2'd3) $display("FAIL sat_count3 got=%0d exp=3", cnt_b); else n_pass++;
    step(); step();
    n_checks++; if (cnt_b !== 2'd3) $display("FAIL sat_hold got=%0d exp=3", cnt_b); else n_pass++;
    ret_b = {IDLE, IDLE}; step(); done_b = 0;
    n_checks++; if (state_b !== {SLEEP, SLEEP}) $display("FAIL out_both_sleep got=%h exp=%h", state_b, {SLEEP, SLEEP}); else n_pass++;
    step();
    n_checks++; if (state_b !== {LAUNCH, SYNC_LAUNCH}) $display("FAIL out_wake got=%h exp=%h", state_b, {LAUNCH, SYNC_LAUNCH}); else n_pass++;
    n_checks++; if (astart_b !== 2'b11) $display("FAIL out_wake_astart got=%b exp=11", astart_b); else n_pass++;
    done_b = 2'b11; ret_b = {IDLE, WAIT}; step(); done_b = 0;
    n_checks++; if (state_b !== {IDLE_STATE, SYNC_WAIT}) $display("FAIL out_finish got=%h exp=%h", state_b, {IDLE_STATE, SYNC_WAIT}); else n_pass++;
    step(); step();
    n_checks++; if (ap_done_b !== 1'b1) $display("FAIL out_done got=%b exp=1", ap_done_b); else n_pass++;
    n_checks++; if (cnt_b !== 2'd3) $display("FAIL out_count_end got=%0d exp=3", cnt_b); else n_pass++;
  endtask

  task automatic test_sleep_timeout();
    start_c = 1; step(); start_c = 0;
    n_checks++; if (state_c !== {LAUNCH, SLEEP}) $display("FAIL to_start got=%h exp=%h", state_c, {LAUNCH, SLEEP}); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      step();
      n_checks++; if (astart_c[0] !== 1'b0) $display("FAIL to_early cycle=%0d got=%b exp=0", k, astart_c[0]); else n_pass++;
    end
    step();
    n_checks++; if (astart_c[0] !== 1'b1) $display("FAIL to_fire got=%b exp=1", astart_c[0]); else n_pass++;
    n_checks++; if (state_c !== {CHECK, LAUNCH}) $display("FAIL to_state got=%h exp=%h", state_c, {CHECK, LAUNCH}); else n_pass++;
    repeat (12) step();
    n_checks++; if (state_c !== {CHECK, CHECK}) $display("FAIL to_busy got=%h exp=%h", state_c, {CHECK, CHECK}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_sync_exec();
    test_start_ignored();
    test_async_reset();
    test_output_lane();
    test_sleep_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_array.md
Name: trigger_array

Overview:
- Multi-lane successor to the single-actor trigger. One instance schedules NUM_LANES actors from a single ap_start/ap_done handshake.
- Sleep/sync consensus (all_sleep, all_sync, all_sync_wait) is computed internally across lanes, not wired externally.
- Adds per-lane mode, a sleep-retry timeout and a saturating execution counter.
- Sits between the network-level control block and the HLS actor instances.

Parameters:
- NUM_LANES, 4, number of actors controlled (1..32).
- LANE_MODES, all ACTOR_TRIGGER, packed mode_t per lane; lane i uses bits [2i+1:2i].
- SLEEP_TIMEOUT, 0, cycles a lane may stay in SLEEP before forced relaunch; 0 disables.
- CNT_W, 32, width of exec_count.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- ap_start  in  1  start request; accepted only when ap_idle=1.
- ap_done  out  1  registered one-cycle pulse when the run completes.
- ap_ready  out  1  equal to ap_done.
- ap_idle  out  1  high when no run is active.
- external_enqueue  in  NUM_LANES  per-lane host enqueue indication.
- actor_return  in  32*NUM_LANES  per-lane return code; lane i uses [32i+31:32i].
- actor_done  in  NUM_LANES  per-lane HLS done.
- actor_idle  in  NUM_LANES  per-lane HLS idle; monitored only.
- actor_start  out  NUM_LANES  per-lane HLS start.
- lane_state  out  4*NUM_LANES  per-lane state_t, for debug.
- exec_count  out  CNT_W  count of EXECUTED returns in the current/last run; saturates.

Behaviour:
- Reset (async, ap_rst_n=0):
  - all lanes IDLE_STATE, running=0, timers=0, exec_count=0.
  - actor_start=0, ap_done=0, ap_idle=1.
- Start: ap_start while running=0 sets running=1 and clears exec_count. On the same edge every lane leaves IDLE_STATE:
  - OUTPUT_TRIGGER lanes -> SLEEP.
  - other lanes -> LAUNCH.
  - ap_start while running=1 is ignored.
- Lane FSM states: IDLE_STATE, LAUNCH, CHECK, SLEEP, SYNC_LAUNCH, SYNC_CHECK, SYNC_WAIT, SYNC_EXEC.
- LAUNCH/CHECK:
  - no done: -> CHECK.
  - done with EXECUTED, TEST, or external_enqueue[i]: ACTOR -> LAUNCH, others -> SLEEP.
  - done otherwise (including IDLE): ACTOR -> SLEEP, others -> IDLE_STATE.
- SLEEP:
  - all_sleep: ACTOR -> SYNC_LAUNCH, others -> LAUNCH.
  - else, SLEEP_TIMEOUT>0 and the lane timer reaches SLEEP_TIMEOUT-1: -> LAUNCH.
  - else stay. The timer resets on SLEEP entry.
- SYNC_LAUNCH/SYNC_CHECK:
  - no done: -> SYNC_CHECK.
  - done with EXECUTED: -> SYNC_EXEC.
  - done with TEST: -> SYNC_LAUNCH.
  - done otherwise: -> SYNC_WAIT.
- SYNC_WAIT: on all_sync, -> IDLE_STATE if all_sync_wait, else LAUNCH.
- SYNC_EXEC: on all_sync, -> LAUNCH.
- Consensus, combinational over the current registered lane states:
  - all_sleep = every lane in SLEEP or IDLE_STATE.
  - all_sync = every lane in SYNC_WAIT, SYNC_EXEC or IDLE_STATE.
  - all_sync_wait = every lane in SYNC_WAIT or IDLE_STATE.
  - Lanes act on the same consensus in the same cycle, so all lanes transition together.
- actor_start[i] = lane in LAUNCH or SYNC_LAUNCH (Moore output, no input path).
- Completion:
  - When running=1 and every lane is IDLE_STATE, the next edge clears running and ap_done pulses exactly one cycle.
  - ap_idle = !running.
  - A new ap_start is accepted on the cycle after the ap_done pulse.
- exec_count:
  - +popcount of lanes with actor_done=1 and actor_return==EXECUTED in LAUNCH, CHECK, SYNC_LAUNCH or SYNC_CHECK.
  - saturates at 2^CNT_W-1; held after run end.
- Simultaneous events:
  - done on the same cycle a lane enters LAUNCH is honoured.
  - a timeout and all_sleep in the same cycle: all_sleep wins.
- Unknown return codes are treated as "not executed".
- Reset mid-run aborts immediately; no ap_done is emitted.

Decomposition:
- Package TriggerTypes (extended, shared):
  - state_t (4-bit enum), mode_t (2-bit: ACTOR_TRIGGER, INPUT_TRIGGER, OUTPUT_TRIGGER).
  - return-code constants IDLE, WAIT, TEST, EXECUTED.
- Sub-module trigger_lane:
  - contents: one lane FSM plus its sleep timer.
  - inputs: mode, consensus bits, done/return/enqueue.
  - outputs: state and start.
  - trigger_array instantiates it NUM_LANES times, plus consensus reduction, run control and counter.

Test Plan:
- NUM_LANES=2, both ACTOR, returns EXECUTED x3 then IDLE on each lane -> both reach SLEEP, then SYNC_LAUNCH; returns WAIT -> both SYNC_WAIT, then IDLE_STATE; one ap_done pulse; exec_count=6.
- Lane0 ACTOR, lane1 OUTPUT; ap_start -> lane1 SLEEP, lane0 LAUNCH; lane0 returns IDLE -> all_sleep -> lane1 LAUNCH on the next edge.
- Sync round where lane0 returns EXECUTED and lane1 WAIT -> both go to LAUNCH when all_sync; no ap_done.
- SLEEP_TIMEOUT=8, lane0 sleeping while lane1 busy for 20 cycles -> lane0 actor_start reasserts exactly 8 cycles after SLEEP entry.
- ap_rst_n low mid-CHECK, asynchronous to the clock -> all outputs reach reset values before the next edge; ap_start pulsed during a run -> ignored.
- CNT_W=2, five EXECUTED returns -> exec_count saturates at 3.
